// File: rtl/output_port_arbiter.sv
// Wormhole round-robin arbiter and credit controller for one mesh-router output port.
// Define OUTPUT_PORT_ARB_PKT_CNT_EN to add the pkt_cnt output and a grant trace.
module output_port_arbiter #(
  parameter int FLIT_W    = 8,
  parameter int BUF_DEPTH = 4,
  parameter int CRED_W    = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          req,
  input  logic [4:0]          in_valid,
  input  logic [5*FLIT_W-1:0] in_data,
  output logic [4:0]          in_ready,
  output logic                out_valid,
  output logic [FLIT_W-1:0]   out_data,
  output logic [4:0]          grant,
  input  logic                credit_in,
  output logic [CRED_W-1:0]   credits,
`ifdef OUTPUT_PORT_ARB_PKT_CNT_EN
  output logic [15:0]         pkt_cnt,
`endif
  output logic                credit_err
);

  // state   | meaning
  // S_IDLE  | no owner; arbitrating among eligible header/single flits
  // S_GRANT | grant_q owns the port until its tail or single flit transfers
  typedef enum logic {S_IDLE = 1'b0, S_GRANT = 1'b1} state_t;

  localparam int NPORT = 5;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(BUF_DEPTH);
  localparam logic [CRED_W-1:0] CRED_ONE = CRED_W'(1);

  state_t              state_q, state_d;
  logic [4:0]          grant_q, grant_d;
  logic [2:0]          rr_ptr_q, rr_ptr_d;
  logic [CRED_W-1:0]   credits_q, credits_d;
  logic                out_valid_q, out_valid_d;
  logic [FLIT_W-1:0]   out_data_q, out_data_d;
  logic                credit_err_q, credit_err_d;

  logic [FLIT_W-1:0]   flit [NPORT];
  logic [NPORT-1:0]    eligible;
  logic [2:0]          cand;
  logic [2:0]          sel_idx;
  logic                sel_vld;
  logic [2:0]          own_idx;
  logic [FLIT_W-1:0]   own_flit;
  logic                own_tail;
  logic                xfer;

  // Header (10) and single (11) flits both have the type MSB set.
  for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
    assign flit[gi]     = in_data[gi*FLIT_W +: FLIT_W];
    assign eligible[gi] = req[gi] & in_valid[gi] & flit[gi][FLIT_W-1];
  end

  // Scan farthest offset first so the nearest eligible port after rr_ptr wins.
  always_comb begin
    sel_idx = '0;
    sel_vld = 1'b0;
    cand    = '0;
    for (int k = NPORT; k >= 1; k--) begin
      cand = 3'((32'(rr_ptr_q) + k) % NPORT);
      if (eligible[cand]) begin
        sel_idx = cand;
        sel_vld = 1'b1;
      end
    end
  end

  always_comb begin
    own_idx = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (grant_q[i]) own_idx = 3'(i);
    end
  end

  assign own_flit = flit[own_idx];
  assign own_tail = own_flit[FLIT_W-2];
  assign xfer     = |(in_valid & in_ready);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      grant_q  <= '0;
      rr_ptr_q <= 3'd4;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (sel_vld) begin
          state_d = S_GRANT;
          grant_d = 5'b00001 << sel_idx;
        end
      end
      S_GRANT: begin
        if (xfer && own_tail) begin
          state_d  = S_IDLE;
          grant_d  = '0;
          rr_ptr_d = own_idx;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready = '0;
    if (state_q == S_GRANT && credits_q != '0) in_ready = grant_q;
  end

  // A simultaneous transfer and credit return cancel, even at full credit.
  always_comb begin
    out_valid_d  = xfer;
    out_data_d   = xfer ? own_flit : out_data_q;
    credits_d    = credits_q;
    credit_err_d = credit_err_q;
    unique case ({xfer, credit_in})
      2'b10: credits_d = credits_q - CRED_ONE;
      2'b01: begin
        if (credits_q == CRED_MAX) credit_err_d = 1'b1;
        else                       credits_d    = credits_q + CRED_ONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      credits_q    <= CRED_MAX;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      credit_err_q <= 1'b0;
    end else begin
      credits_q    <= credits_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      credit_err_q <= credit_err_d;
    end
  end

`ifdef OUTPUT_PORT_ARB_PKT_CNT_EN
  logic [15:0] pkt_cnt_q, pkt_cnt_d;

  assign pkt_cnt_d = (xfer && own_tail) ? pkt_cnt_q + 16'd1 : pkt_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_cnt_q <= '0;
    end else begin
      pkt_cnt_q <= pkt_cnt_d;
      if (state_q == S_IDLE && sel_vld)
        $display("output_port_arbiter: grant to port %0d", sel_idx);
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`endif

  assign grant      = grant_q;
  assign credits    = credits_q;
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign credit_err = credit_err_q;

endmodule

// File: doc/output_port_arbiter.md
Name: output_port_arbiter

Overview:
- Per-output-port wormhole arbiter and credit controller for the 4x4 mesh router.
- Sits after the five route-compute blocks: each input port raises its one-hot request toward this output port. Requesters are Local, East, North, West and South.
- Grants one input per packet using round-robin, and holds the grant from header flit to tail flit.
- Forwards flits only while downstream buffer credits are available, and registers the output flit.

Parameters:
- FLIT_W, 8, flit width in bits. Bits [FLIT_W-1:FLIT_W-2] carry the flit type: 2'b10 header, 2'b00 body, 2'b01 tail, 2'b11 single-flit packet (header and tail in one flit).
- BUF_DEPTH, 4, downstream input-buffer depth; initial and maximum credit count.
- CRED_W, 3, credit counter width; must hold BUF_DEPTH.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-low reset (asserted when 0, sampled on the clk edge).
- req  input  5  requests from route compute toward this port. Bit0 Local, bit1 East, bit2 North, bit3 West, bit4 South.
- in_valid  input  5  per-input flit valid.
- in_data  input  5*FLIT_W  flattened input flits; input i occupies slice [i*FLIT_W +: FLIT_W].
- in_ready  output  5  per-input flit accept.
- out_valid  output  1  registered output flit valid.
- out_data  output  FLIT_W  registered output flit.
- grant  output  5  one-hot current owner; all zero when idle.
- credit_in  input  1  one credit returned by downstream this cycle.
- credits  output  CRED_W  current credit count.
- credit_err  output  1  sticky credit overflow flag.

Behaviour:
- Reset (rst==0 at a clk edge):
  - state=IDLE, grant=0, rr_ptr=4 (so Local has highest priority first).
  - credits=BUF_DEPTH, out_valid=0, out_data=0, in_ready=0, credit_err=0.
- An input i is eligible when req[i], in_valid[i] and the flit type is header or single-flit.
- State IDLE:
  - in_ready=0.
  - If any input is eligible, select the first eligible index searching rr_ptr+1, rr_ptr+2, ... modulo 5.
  - On the next edge: grant=onehot(sel), state=GRANT.
  - Non-header flits are never eligible in IDLE; they wait.
- State GRANT (owner g):
  - in_ready[g] = (credits != 0). All other in_ready bits are 0.
  - Transfer occurs when in_valid[g] && in_ready[g].
  - On a transfer, the next edge sets out_valid=1 and out_data=in_data[g]. Latency is exactly 1 cycle.
  - With no transfer, out_valid=0 on the next edge and out_data holds its value.
  - If the transferred flit is a tail or single-flit: on the next edge state=IDLE, grant=0, rr_ptr=g.
  - Header or body flits keep the grant. req[g] dropping mid-packet does not release the grant.
  - A header type arriving mid-packet is forwarded as data; there is no error.
- Minimum turnaround: one idle arbitration cycle between packets.
- Credits:
  - Transfer only: credits-1.
  - credit_in only: credits+1.
  - Both in the same cycle: unchanged.
  - credit_in while credits==BUF_DEPTH with no transfer: credits stays at BUF_DEPTH and credit_err is set to 1 (sticky until reset).
  - credits==0: in_ready[g]=0 and the packet stalls, grant held.
  - Credits never underflow.
- A reset mid-packet aborts the packet. All state returns to reset values and the credits reload.
- All outputs are registered except in_ready, which is combinational from state, grant and credits.

Optional Feature:
- Macro: OUTPUT_PORT_ARB_PKT_CNT_EN.
- When defined:
  - Adds output port pkt_cnt, 16 bits, reset to 0.
  - pkt_cnt increments on each transferred tail or single-flit, and wraps from 16'hFFFF to 0.
  - Adds `$display` of the winning port index at each grant.
- When undefined: the port and counter are absent and the rest of the behaviour is identical.

Test Plan:
- Reset, then Local sends single-flit 8'hC5 (type 11) with req=5'b00001 → grant=00001 after 1 cycle; out_valid pulse with out_data=8'hC5; credits 4→3; back to IDLE.
- East and South both request headers in the same cycle with rr_ptr=4 → grant East first. After East's tail, South is granted next, with 1 idle cycle between packets.
- Header, body, body, tail from North with no credit_in → credits reach 0 after 4 flits. Feed a 5-flit packet: the 5th flit stalls with in_ready=0 until a credit_in pulse, then it transfers and the grant releases.
- credit_in in the same cycle as a transfer at credits=2 → credits stays 2. Pulse credit_in at credits=4 → credits stays 4 and credit_err=1, which persists.
- Drop rst mid-packet (after the West body flit) → next edge: grant=0, credits=4, out_valid=0; a new header from Local is arbitrated normally.
- A body flit (type 00) presented with req set in IDLE → no grant and in_ready=0 for 10 cycles.
